mac_unit: RTL and testbench

Iterative multiply-accumulate engine for MADD/MADDU/MSUB/MSUBU in the EX stage of the five-stage MIPS32 pipeline. It takes two 32-bit operands plus the current HI/LO value and produces the 64-bit accumulated HI/LO result using a 32-cycle shift-add multiplier. While busy it raises a stall request to the pipeline controller, which holds the front of the pipeline and inserts bubbles into the EX/MEM register. When the result is ready, EX forwards it into the EX/MEM register as the HI/LO write data.

---
 rtl/mac_unit_pkg.sv | 19 +
 rtl/mac_unit_if.sv | 25 ++
 rtl/mac_unit.sv | 96 +++++++++
 tb/tb_mac_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_unit_pkg.sv
// Shared types and constants for the iterative MADD/MADDU/MSUB/MSUBU engine.
package mac_unit_pkg;

    localparam int MAC_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } mac_state_e;

    // Per-operation controls captured when start is accepted.
    typedef struct packed {
        logic neg;
        logic sub;
    } mac_ctl_t;

endpackage

// File: rtl/mac_unit_if.sv
// EX-stage <-> MAC engine signal bundle; the engine takes the slave side.
interface mac_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_op;
    logic                 sub_op;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic [2*WIDTH-1:0]   hilo_i;
    logic                 annul;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start, signed_op, sub_op, opdata1, opdata2, hilo_i, annul,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start, signed_op, sub_op, opdata1, opdata2, hilo_i, annul,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/mac_unit.sv
// Iterative multiply-accumulate: 32-cycle shift-add on magnitudes, then sign
// fix-up and HI/LO add/subtract in one ACC cycle.
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    mac_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int DW    = 2 * WIDTH;

    mac_state_e         r_state;
    mac_state_e         w_state_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [DW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [DW-1:0]      r_prod;
    logic [DW-1:0]      r_hilo;
    logic [DW-1:0]      r_result;
    mac_ctl_t           r_ctl;

    logic               w_accept;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [DW-1:0]      w_p;
    logic [DW-1:0]      w_acc;

    // Negating the most negative value yields 2^(WIDTH-1), which is exact unsigned.
    assign w_mag1 = (bus.signed_op && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    assign w_mag2 = (bus.signed_op && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.annul;

    assign w_p   = r_ctl.neg ? -r_prod : r_prod;
    assign w_acc = r_ctl.sub ? (r_hilo - w_p) : (r_hilo + w_p);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_n = S_MUL;
            S_MUL:  if (r_cnt == CNT_W'(WIDTH - 1)) w_state_n = S_ACC;
            S_ACC:  w_state_n = S_DONE;
            S_DONE: w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
        if (bus.annul) w_state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_hilo   <= '0;
            r_ctl    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_prod    <= '0;
                r_mcand   <= {{WIDTH{1'b0}}, w_mag1};
                r_mplier  <= w_mag2;
                r_hilo    <= bus.hilo_i;
                r_ctl.neg <= bus.signed_op & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                r_ctl.sub <= bus.sub_op;
            end else if (r_state == S_MUL) begin
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
            // A flush during ACC must leave the previous result visible.
            if ((r_state == S_ACC) && !bus.annul) r_result <= w_acc;
        end
    end

    assign bus.result_o   = r_result;
    assign bus.ready_o    = (r_state == S_DONE) && !bus.annul;
    assign bus.stallreq_o = rst && !bus.annul &&
                            (((r_state == S_IDLE) && bus.start) ||
                             (r_state == S_MUL) || (r_state == S_ACC));

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed table, random ops vs arithmetic
// model, flush and asynchronous-reset sequences.
module tb_mac_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mac_unit_if #(.WIDTH(32)) bus ();

    mac_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        bit           s;
        bit           sub;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [63:0]  h;
        logic [63:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Model: full-precision product via 64-bit integer arithmetic, wrapped mod 2^64.
    function automatic logic [63:0] ref_mac(input bit s, input bit sub,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [63:0] h);
        longint sa;
        longint sb;
        logic [63:0] p;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        return sub ? (h - p) : (h + p);
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after ready.
    task automatic do_op(input bit s, input bit sub, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] h,
                         output logic [63:0] res, output int lat, output bit stall_ok);
        bus.signed_op = s;
        bus.sub_op    = sub;
        bus.opdata1   = a;
        bus.opdata2   = b;
        bus.hilo_i    = h;
        bus.start     = 1'b1;
        lat      = -1;
        stall_ok = 1'b1;
        res      = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                lat = k;
                res = bus.result_o;
                if (bus.stallreq_o) stall_ok = 1'b0;
                break;
            end
            if (!bus.stallreq_o) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus.opdata1   = $urandom;
                bus.opdata2   = $urandom;
                bus.hilo_i    = {$urandom, $urandom};
                bus.signed_op = ~s;
                bus.sub_op    = ~sub;
            end
        end
        if (lat < 0) res = bus.result_o;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_check(input string name, input bit s, input bit sub,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] h, input logic [63:0] exp,
                             output logic [63:0] res);
        int lat;
        bit sok;
        do_op(s, sub, a, b, h, res, lat, sok);
        chk({name, " latency"}, 64'(lat), 64'd34);
        chk({name, " stall"}, 64'(sok), 64'd1);
        chk({name, " result"}, res, exp);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [63:0] res;
        logic [63:0] prev;
        bit          saw_rdy;
        bit          saw_stall;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"maddu_3x5",   1'b0, 1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000A, 64'h0000_0000_0000_0019};
        vecs[1] = '{"madd_m2x3",   1'b1, 1'b0, 32'hFFFF_FFFE,  32'd3,          64'h0,                   64'hFFFF_FFFF_FFFF_FFFA};
        vecs[2] = '{"msub_minsq",  1'b1, 1'b1, 32'h8000_0000,  32'h8000_0000,  64'h0000_0000_0000_000A, 64'hC000_0000_0000_000A};
        vecs[3] = '{"maddu_wrap",  1'b0, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0000};
        vecs[4] = '{"msubu_1x1",   1'b0, 1'b1, 32'd1,          32'd1,          64'h0,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{"madd_m1xm1",  1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h5,                   64'h6};

        bus.start = 1'b1;
        bus.signed_op = 1'b0;
        bus.sub_op = 1'b0;
        bus.opdata1 = '0;
        bus.opdata2 = '0;
        bus.hilo_i = '0;
        bus.annul = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset result", bus.result_o, 64'h0);
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset stall", 64'(bus.stallreq_o), 64'd0);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // annul wins over start in IDLE: no stall, nothing accepted
        bus.start = 1'b1;
        bus.annul = 1'b1;
        #1;
        chk("idle annul stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        saw_rdy = 1'b0;
        saw_stall = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) saw_rdy = 1'b1;
            if (bus.stallreq_o) saw_stall = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("idle annul ready", 64'(saw_rdy), 64'd0);
        chk("idle annul no-op", 64'(saw_stall), 64'd0);

        foreach (vecs[i])
            run_check(vecs[i].name, vecs[i].s, vecs[i].sub, vecs[i].a, vecs[i].b,
                      vecs[i].h, vecs[i].exp, res);

        for (int i = 0; i < 16; i++) begin
            bit s;
            bit sub;
            logic [31:0] a;
            logic [31:0] b;
            logic [63:0] h;
            s   = 1'($urandom);
            sub = 1'($urandom);
            a   = (i % 5 == 0) ? 32'h8000_0000 : 32'($urandom);
            b   = (i % 7 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            h   = {32'($urandom), 32'($urandom)};
            run_check("random", s, sub, a, b, h, ref_mac(s, sub, a, b, h), res);
        end
        prev = bus.result_o;

        // Flush in the 10th MUL cycle
        bus.signed_op = 1'b0;
        bus.sub_op = 1'b0;
        bus.opdata1 = 32'd7;
        bus.opdata2 = 32'd9;
        bus.hilo_i = 64'h0;
        bus.start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.annul = 1'b1;
        #1;
        chk("annul stall drop", 64'(bus.stallreq_o), 64'd0);
        chk("annul ready", 64'(bus.ready_o), 64'd0);
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        bus.start = 1'b0;
        saw_rdy = 1'b0;
        saw_stall = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o) saw_rdy = 1'b1;
            if (bus.stallreq_o) saw_stall = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("annul no ready", 64'(saw_rdy), 64'd0);
        chk("annul idle", 64'(saw_stall), 64'd0);
        chk("annul result held", bus.result_o, prev);
        run_check("after annul 2x2", 1'b0, 1'b0, 32'd2, 32'd2, 64'h0, 64'h4, res);

        // Asynchronous reset between edges during MUL
        bus.opdata1 = 32'd11;
        bus.opdata2 = 32'd13;
        bus.start = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst result", bus.result_o, 64'h0);
        chk("midrst ready", 64'(bus.ready_o), 64'd0);
        chk("midrst stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        bus.opdata1 = 32'd3;
        bus.opdata2 = 32'd5;
        bus.hilo_i = 64'hA;
        bus.start = 1'b1;
        rst_n = 1'b1;
        run_check("post reset", 1'b0, 1'b0, 32'd3, 32'd5, 64'hA, 64'h19, res);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
